program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Boot-time stage directly upstream of the multicycle CPU datapath. Accepts a program image as a
//   32-bit valid/ready word stream (header word = payload length, then payload words) and writes each
//   payload word into main memory at consecutive word addresses. Holds the core stopped until the image
//   is complete and valid. Top level muxes mem_* onto the main-memory write port while busy=1.
// PARAMETERS
//   DATA_W     32    stream/memory word width
//   ADDR_W     32    memory address width (word addresses, matches PC width)
//   BASE_ADDR  0     address of first payload word (reset PC value)
//   MAX_WORDS  1024  largest legal payload length
// PORTS
//   clk           in   1       system clock, all logic on rising edge
//   rst           in   1       asynchronous, active-low reset
//   start         in   1       1-cycle pulse: begin a load (honoured in IDLE and ERROR only)
//   s_valid       in   1       stream word valid
//   s_data        in   DATA_W  stream word
//   s_ready       out  1       loader can accept s_data this cycle
//   mem_we        out  1       memory write strobe (1 cycle per payload word)
//   mem_addr      out  ADDR_W  memory write address
//   mem_wdata     out  DATA_W  memory write data
//   cpu_run       out  1       core released; drives the core's reset release
//   busy          out  1       loader owns the memory port
//   done          out  1       image loaded successfully (sticky)
//   error         out  1       bad header or checksum (sticky until next start)
//   words_loaded  out  ADDR_W  payload words written so far
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; all outputs 0; mem_we drops immediately.
//   - Handshake: word transfers when s_valid && s_ready on a rising edge. s_ready is combinational from
//     state only (1 in HDR, LOAD, CHECK; else 0); never depends on s_valid.
//   - States: IDLE -> HDR on start. HDR: accepted word N; N==0 or N>MAX_WORDS -> ERROR, else
//     latch N, idx=0 -> LOAD. LOAD: per accepted word, register mem_we=1, mem_addr=BASE_ADDR+idx,
//     mem_wdata=s_data (write visible the cycle after handshake), idx++, words_loaded=idx+1.
//     After N-th word -> CHECK (macro on) or DONE (macro off). CHECK/DONE/ERROR described below.
//   - DONE: busy=0, done=1, cpu_run=1 from the cycle after the last memory write; terminal until rst.
//   - ERROR: busy=0, error=1, cpu_run=0; start -> HDR, clears error, words_loaded, checksum.
//   - busy=1 in HDR, LOAD, CHECK and during the trailing mem_we cycle.
//   - start outside IDLE/ERROR ignored. s_valid while s_ready=0 ignored, no data lost (source holds).
//   - Stalls: gaps in s_valid are unbounded; no timeout.
//   - Address arithmetic modulo 2^ADDR_W; with legal MAX_WORDS no wrap occurs.
//   - rst mid-load: image abandoned, partial memory contents left as-is, cpu_run stays 0.
// CONFIGURATION
//   PROGRAM_LOADER_CHECKSUM_EN defined: after payload, CHECK state accepts one word; it must equal the
//     32-bit wrap-around sum of all payload words -> DONE, else -> ERROR (memory already written,
//     cpu_run stays 0). Accumulator cleared on start.
//   Not defined: no CHECK state, no accumulator; LOAD goes straight to DONE.
// STRUCTURE
//   program_loader_pkg: state encoding (IDLE, HDR, LOAD, CHECK, DONE, ERROR) as localparams,
//     HDR_LEN_ZERO / HDR_LEN_MAX error-cause constants, shared stream word width.
//   Sub-module: loader_checksum (clear/add/value accumulator), instantiated only under the macro.
// TESTING
//   1. start, stream {3, 0xA, 0xB, 0xC} -> mem writes @0,1,2 = A,B,C; done=1, cpu_run=1, words_loaded=3.
//   2. Header 0 -> error=1, no mem_we; start again + {1, 0x5} -> done=1, mem[0]=5.
//   3. Header MAX_WORDS+1 -> error=1; cpu_run=0; s_ready=0 until next start.
//   4. Macro on: {2, 0x1, 0x2, 0x3} -> done; {2, 0x1, 0x2, 0x4} -> error, cpu_run=0.
//   5. s_valid toggling every other cycle, start pulsed in LOAD -> same writes as case 1, start ignored.
//   6. rst low after 2nd payload word of case 1 -> outputs 0 immediately, state IDLE, mem_we=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: stream word width, FSM states and header check causes.
package program_loader_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    HDR_OK,
    HDR_LEN_ZERO,
    HDR_LEN_MAX
  } hdr_cause_e;

  function automatic hdr_cause_e check_header(input logic [WORD_W-1:0] n,
                                              input int unsigned max_words);
    if (n == '0) return HDR_LEN_ZERO;
    if (n > max_words) return HDR_LEN_MAX;
    return HDR_OK;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready word stream carrying the program image into the loader.
interface program_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/program_loader_checksum.sv
// Wrap-around sum of payload words, cleared at the start of each load.
module loader_checksum
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       value <= '0;
    else if (clear) value <= '0;
    else if (add)   value <= value + data;
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header word (payload length) then payload words written to consecutive memory addresses.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing wrap-around sum word after the payload.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned       DATA_W    = WORD_W,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  program_loader_if.slave     stream,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                cpu_run,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   words_loaded
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d, words_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic                csum_clear, csum_add;
  logic [DATA_W-1:0]   csum_value;

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk   (clk),
    .rst   (rst),
    .clear (csum_clear),
    .add   (csum_add),
    .data  (stream.s_data),
    .value (csum_value)
  );
`endif

  assign stream.s_ready = (state_q inside {ST_HDR, ST_LOAD, ST_CHECK});
  assign accept         = stream.s_ready && stream.s_valid;
  // The trailing write cycle still owns the memory port, and the core is released only after it.
  assign busy           = stream.s_ready || mem_we;
  assign done           = (state_q == ST_DONE) && !mem_we;
  assign cpu_run        = done;
  assign error          = (state_q == ST_ERROR);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    words_d = words_loaded;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_clear = 1'b0;
    csum_add   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d = ST_HDR;
          words_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_clear = 1'b1;
`endif
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (check_header(WORD_W'(stream.s_data), MAX_WORDS) != HDR_OK) begin
            state_d = ST_ERROR;
          end else begin
            len_d   = ADDR_W'(stream.s_data);
            idx_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = stream.s_data;
          idx_d   = idx_q + ADDR_W'(1);
          words_d = idx_q + ADDR_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_add = 1'b1;
          if (idx_d == len_q) state_d = ST_CHECK;
`else
          if (idx_d == len_q) state_d = ST_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (stream.s_data == csum_value) ? ST_DONE : ST_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      mem_we       <= we_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      words_loaded <= words_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a transfer-level reference model.
module tb_program_loader;

  localparam int unsigned MAXW = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_we, cpu_run, busy, done, error;
  logic [31:0] mem_addr, mem_wdata, words_loaded;

  always #5 clk = ~clk;

  program_loader_if #(.DATA_W(32)) sif();

  program_loader #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stream       (sif),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reacts to each transfer the spec allows, in terms of image phases.
  typedef enum int {P_IDLE, P_HDR, P_LOAD, P_CHECK, P_DONE, P_ERR} phase_t;
  phase_t      ph = P_IDLE;
  int unsigned m_len = 0;
  int unsigned m_n = 0;
  logic [31:0] m_sum = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_pdata = '0;
  bit          m_acc;

  function automatic bit m_ready();
    return (ph == P_HDR) || (ph == P_LOAD) || (ph == P_CHECK);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = P_IDLE; m_len = 0; m_n = 0; m_sum = '0; m_pend = 1'b0;
    end else begin
      m_acc  = m_ready() && sif.s_valid;
      m_pend = 1'b0;
      if ((ph == P_IDLE || ph == P_ERR) && start) begin
        ph = P_HDR; m_n = 0; m_sum = '0;
      end else if (m_acc && ph == P_HDR) begin
        if (sif.s_data == 0 || sif.s_data > MAXW) ph = P_ERR;
        else begin m_len = sif.s_data; m_n = 0; ph = P_LOAD; end
      end else if (m_acc && ph == P_LOAD) begin
        m_pend  = 1'b1;
        m_paddr = BASE + m_n;
        m_pdata = sif.s_data;
        m_sum   = m_sum + sif.s_data;
        m_n++;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (m_n == m_len) ph = P_CHECK;
`else
        if (m_n == m_len) ph = P_DONE;
`endif
      end else if (m_acc && ph == P_CHECK) begin
        ph = (sif.s_data == m_sum) ? P_DONE : P_ERR;
      end
    end
  end

  logic [31:0] dut_mem [logic [31:0]];
  int          we_cnt = 0;

  always @(negedge clk) begin
    chk1("s_ready", sif.s_ready, m_ready());
    chk1("mem_we", mem_we, m_pend);
    if (m_pend) begin
      chk("mem_addr", mem_addr, m_paddr);
      chk("mem_wdata", mem_wdata, m_pdata);
    end
    chk1("busy", busy, m_ready() || m_pend);
    chk1("done", done, ph == P_DONE && !m_pend);
    chk1("cpu_run", cpu_run, ph == P_DONE && !m_pend);
    chk1("error", error, ph == P_ERR);
    chk("words_loaded", words_loaded, m_n);
    if (mem_we === 1'b1) begin
      dut_mem[mem_addr] = mem_wdata;
      we_cnt++;
    end
  end

  logic [31:0] img[$];

  task automatic seal_img();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] s = '0;
    for (int i = 1; i < img.size(); i++) s = s + img[i];
    img.push_back(s);
`endif
  endtask

  task automatic push(input logic [31:0] w, input int gap);
    int  n = 0;
    bit  taken = 0;
    repeat (gap) begin
      sif.s_valid = 1'b0; sif.s_data = $urandom; @(posedge clk); #1;
    end
    sif.s_valid = 1'b1; sif.s_data = w;
    while (!taken) begin
      @(negedge clk);
      if (sif.s_ready) taken = 1;
      @(posedge clk); #1;
      n++;
      if (!taken && n > 40) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: word %h not accepted in 40 cycles", w);
        taken = 1;
      end
    end
    sif.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic load_img(input bit gaps);
    pulse_start();
    foreach (img[i]) push(img[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dut_mem.delete();
    we_cnt = 0;
  endtask

  task automatic check_mem(input int unsigned len);
    chk("mem_count", dut_mem.size(), len);
    for (int unsigned i = 0; i < len; i++) begin
      if (dut_mem.exists(BASE + i)) chk("mem_content", dut_mem[BASE + i], img[i + 1]);
      else chk("mem_missing_addr", BASE + i, 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    sif.s_valid = 1'b0; sif.s_data = '0;
    do_reset();
    chk1("reset_mem_we", mem_we, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_cpu_run", cpu_run, 1'b0);
    chk("reset_words", words_loaded, 32'd0);

    // Case 1: plain three-word image
    img = '{32'd3, 32'hA, 32'hB, 32'hC}; seal_img();
    load_img(0); settle();
    chk1("c1_done", done, 1'b1);
    chk1("c1_cpu_run", cpu_run, 1'b1);
    chk("c1_words", words_loaded, 32'd3);
    chk("c1_mem0", dut_mem.exists(0) ? dut_mem[0] : 32'hDEAD, 32'hA);
    chk("c1_mem2", dut_mem.exists(2) ? dut_mem[2] : 32'hDEAD, 32'hC);
    check_mem(3);

    // Case 2: zero-length header, then a retry from ERROR
    do_reset();
    pulse_start(); push(32'd0, 0); settle();
    chk1("c2_error", error, 1'b1);
    chk("c2_no_writes", we_cnt, 32'd0);
    img = '{32'd1, 32'h5}; seal_img();
    load_img(0); settle();
    chk1("c2_done", done, 1'b1);
    chk1("c2_error_cleared", error, 1'b0);
    chk("c2_mem0", dut_mem.exists(0) ? dut_mem[0] : 32'hDEAD, 32'h5);

    // Case 3: header one past the limit
    do_reset();
    pulse_start(); push(MAXW + 1, 0); settle();
    chk1("c3_error", error, 1'b1);
    chk1("c3_cpu_run", cpu_run, 1'b0);
    chk1("c3_s_ready", sif.s_ready, 1'b0);
    chk("c3_no_writes", we_cnt, 32'd0);
    pulse_start(); settle();
    chk1("c3_restart_ready", sif.s_ready, 1'b1);

    // Largest legal length
    do_reset();
    img = '{MAXW};
    for (int unsigned i = 0; i < MAXW; i++) img.push_back($urandom);
    seal_img();
    load_img(1); settle();
    chk1("max_done", done, 1'b1);
    chk("max_words", words_loaded, MAXW);
    check_mem(MAXW);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Case 4: checksum accept and reject
    do_reset();
    img = '{32'd2, 32'h1, 32'h2, 32'h3};
    load_img(0); settle();
    chk1("c4_done", done, 1'b1);
    do_reset();
    img = '{32'd2, 32'h1, 32'h2, 32'h4};
    load_img(0); settle();
    chk1("c4_error", error, 1'b1);
    chk1("c4_cpu_run", cpu_run, 1'b0);
    chk("c4_written", we_cnt, 32'd2);
`endif

    // Case 5: stalled stream with a start pulse during LOAD
    do_reset();
    img = '{32'd3, 32'hA, 32'hB, 32'hC}; seal_img();
    pulse_start();
    push(img[0], 1); push(img[1], 2);
    pulse_start();
    for (int i = 2; i < img.size(); i++) push(img[i], (i % 2 == 0) ? 1 : 0);
    settle();
    chk1("c5_done", done, 1'b1);
    chk("c5_words", words_loaded, 32'd3);
    check_mem(3);

    // Case 6: reset after the second payload word
    do_reset();
    pulse_start();
    push(32'd3, 0); push(32'hA, 0); push(32'hB, 0);
    #2 rst = 1'b0;
    #1;
    chk1("c6_mem_we", mem_we, 1'b0);
    chk1("c6_busy", busy, 1'b0);
    chk1("c6_s_ready", sif.s_ready, 1'b0);
    chk1("c6_cpu_run", cpu_run, 1'b0);
    chk("c6_words", words_loaded, 32'd0);
    chk("c6_mem_addr", mem_addr, 32'd0);
    chk("c6_writes_seen", dut_mem.size(), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    settle();
    chk1("c6_idle_ready", sif.s_ready, 1'b0);

    // Random images
    for (int t = 0; t < 8; t++) begin
      int unsigned len;
      do_reset();
      len = $urandom_range(1, MAXW);
      img = '{len};
      for (int unsigned i = 0; i < len; i++) img.push_back($urandom);
      seal_img();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (t % 3 == 2) img[img.size() - 1] = img[img.size() - 1] ^ 32'h1;
`endif
      load_img(1); settle();
      check_mem(len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
